// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the parametrised register bank.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read forwarding).
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 3;

  // True when addr names the hard-wired zero register of a ZERO_REG build.
  function automatic logic is_zero_addr(input logic [31:0] addr, input bit zero_reg);
    return zero_reg && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: DEPTH:1 data mux, zero-register forcing and busy lookup.
// With REGFILE_BYPASS_EN defined, an accepted same-cycle write to raddr_i is forwarded.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0]               raddr_i,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   mem_i,
  input  logic [(2**ADDR_W)-1:0]          pend_i,
  input  logic                            wr_acc_i,
  input  logic [ADDR_W-1:0]               wa_i,
  input  logic [DATA_W-1:0]               wd_i,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            busy_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] stored;
  logic              zero_sel;
  logic              fwd;

  assign zero_sel = is_zero_addr(32'(raddr_i), ZERO_REG);

  always_comb begin
    stored = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr_i == ADDR_W'(i)) begin
        stored = mem_i[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd = wr_acc_i && (wa_i == raddr_i);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_acc_i, wa_i};
  assign fwd = 1'b0;
`endif

  assign rdata_o = zero_sel ? '0 : (fwd ? wd_i : stored);
  assign busy_o  = zero_sel ? 1'b0 : pend_i[raddr_i];

endmodule

// File: rtl/regfile_param_bank.sv
// 2^ADDR_W x DATA_W register file: one write port, two read ports, pending-write
// scoreboard and a one-entry-per-cycle bulk-clear sweep. Macro: REGFILE_BYPASS_EN.
module regfile_param_bank
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       mem_d [DEPTH];
  logic [DEPTH-1:0]        pend_q, pend_d;
  clr_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    wr_acc, rsv_acc;
  logic [DEPTH*DATA_W-1:0] mem_flat;

  assign clr_busy = (state_q == SWEEP);
  assign wr_acc   = we     && !clr_busy && !is_zero_addr(32'(wa), ZERO_REG);
  assign rsv_acc  = rsv_en && !clr_busy && !is_zero_addr(32'(rsv_addr), ZERO_REG);

  always_comb begin : clr_fsm
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reservation is applied after the write so a same-address pair leaves pend set.
  always_comb begin : storage_next
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clr_busy) begin
      mem_d[idx_q]  = '0;
      pend_d[idx_q] = 1'b0;
    end else begin
      if (wr_acc) begin
        mem_d[wa]  = wd;
        pend_d[wa] = 1'b0;
      end
      if (rsv_acc) begin
        pend_d[rsv_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rp1 (
    .raddr_i  (ra1),
    .mem_i    (mem_flat),
    .pend_i   (pend_q),
    .wr_acc_i (wr_acc),
    .wa_i     (wa),
    .wd_i     (wd),
    .rdata_o  (rd1),
    .busy_o   (busy1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rp2 (
    .raddr_i  (ra2),
    .mem_i    (mem_flat),
    .pend_i   (pend_q),
    .wr_acc_i (wr_acc),
    .wa_i     (wa),
    .wd_i     (wd),
    .rdata_o  (rd2),
    .busy_o   (busy2)
  );

endmodule

// File: tb/tb_regfile_param_bank.sv
// Bench for regfile_param_bank: a ZERO_REG=1 and a ZERO_REG=0 instance share all inputs
// and are compared against a behavioural array model; REGFILE_BYPASS_EN changes expectations.
module tb_regfile_param_bank;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, we, rsv_en, clr_req;
  logic [AW-1:0] wa, ra1, ra2, rsv_addr;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd1_z, rd2_z, rd1_o, rd2_o;
  logic          busy1_z, busy2_z, clr_busy_z, busy1_o, busy2_o, clr_busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents and pending flags per instance, plus sweep progress.
  logic [DW-1:0]    mz [DEPTH];
  logic [DW-1:0]    mo [DEPTH];
  logic [DEPTH-1:0] pz, po;
  bit               sw_on;
  int               sw_pos;

  always #5 clk = ~clk;

  regfile_param_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_z), .rd2(rd2_z), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1_z), .busy2(busy2_z), .clr_req(clr_req), .clr_busy(clr_busy_z)
  );

  regfile_param_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut_o (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_o), .rd2(rd2_o), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(busy1_o), .busy2(busy2_o), .clr_req(clr_req), .clr_busy(clr_busy_o)
  );

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin mz[i] = '0; mo[i] = '0; end
      pz = '0; po = '0; sw_on = 0; sw_pos = 0;
    end else if (sw_on) begin
      mz[sw_pos] = '0; mo[sw_pos] = '0; pz[sw_pos] = 1'b0; po[sw_pos] = 1'b0;
      sw_pos++;
      if (sw_pos == DEPTH) sw_on = 0;
    end else begin
      if (we) begin
        if (wa != 0) begin mz[wa] = wd; pz[wa] = 1'b0; end
        mo[wa] = wd; po[wa] = 1'b0;
      end
      if (rsv_en) begin
        if (rsv_addr != 0) pz[rsv_addr] = 1'b1;
        po[rsv_addr] = 1'b1;
      end
      if (clr_req) begin sw_on = 1; sw_pos = 0; end
    end
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit zr, input logic [AW-1:0] a);
    if (zr && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !sw_on && !(zr && wa == 0) && a == wa) return wd;
`endif
    return zr ? mz[a] : mo[a];
  endfunction

  function automatic logic exp_busy(input bit zr, input logic [AW-1:0] a);
    if (zr && a == 0) return 1'b0;
    return zr ? pz[a] : po[a];
  endfunction

  task automatic idle_inputs();
    we = 0; wa = '0; wd = '0; rsv_en = 0; rsv_addr = '0; clr_req = 0;
  endtask

  task automatic test_reset();
    rst = 1; we = 1; wa = 3'd3; wd = 8'hFF; rsv_en = 1; rsv_addr = 3'd3; clr_req = 1;
    ra1 = 3'd3; ra2 = 3'd7;
    tick();
    rst = 0; idle_inputs();
    #1;
    n_tests++; if (rd1_z !== 8'h00) begin n_fail++; $display("FAIL reset_rd1: got %h want 00", rd1_z); end
    n_tests++; if (rd2_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd2_o: got %h want 00", rd2_o); end
    n_tests++; if (busy1_z !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1_z); end
    n_tests++; if (clr_busy_z !== 1'b0 || clr_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b/%b want 0/0", clr_busy_z, clr_busy_o); end
  endtask

  task automatic test_write_read();
    we = 1; wa = 3'd3; wd = 8'hA5; tick();
    wa = 3'd7; wd = 8'h3C; tick();
    we = 0; ra1 = 3'd3; ra2 = 3'd7; #1;
    n_tests++; if (rd1_z !== 8'hA5) begin n_fail++; $display("FAIL wr_rd1: got %h want A5", rd1_z); end
    n_tests++; if (rd2_z !== 8'h3C) begin n_fail++; $display("FAIL wr_rd2: got %h want 3C", rd2_z); end
    we = 1; wa = 3'd0; wd = 8'hFF; tick();
    we = 0; ra1 = 3'd0; #1;
    n_tests++; if (rd1_z !== 8'h00) begin n_fail++; $display("FAIL zero_reg_rd: got %h want 00", rd1_z); end
    n_tests++; if (rd1_o !== 8'hFF) begin n_fail++; $display("FAIL plain_reg0_rd: got %h want FF", rd1_o); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 3'd5; tick();
    rsv_en = 0; ra1 = 3'd5; #1;
    n_tests++; if (busy1_z !== 1'b1) begin n_fail++; $display("FAIL rsv_busy: got %b want 1", busy1_z); end
    we = 1; wa = 3'd5; wd = 8'h11; tick();
    we = 0; #1;
    n_tests++; if (busy1_z !== 1'b0 || rd1_z !== 8'h11) begin n_fail++; $display("FAIL release: got busy %b rd %h want 0 11", busy1_z, rd1_z); end
    we = 1; wa = 3'd2; wd = 8'h77; rsv_en = 1; rsv_addr = 3'd2; tick();
    we = 0; rsv_en = 0; ra2 = 3'd2; #1;
    n_tests++; if (busy2_z !== 1'b1 || rd2_z !== 8'h77) begin n_fail++; $display("FAIL rsv_wins: got busy %b rd %h want 1 77", busy2_z, rd2_z); end
    we = 1; wa = 3'd4; wd = 8'h44; rsv_en = 1; rsv_addr = 3'd6; tick();
    we = 0; rsv_en = 0; ra1 = 3'd4; ra2 = 3'd6; #1;
    n_tests++; if (busy1_z !== 1'b0 || rd1_z !== 8'h44 || busy2_z !== 1'b1) begin n_fail++; $display("FAIL split_wr_rsv: got %b %h %b want 0 44 1", busy1_z, rd1_z, busy2_z); end
    we = 1; wa = 3'd0; wd = 8'h42; tick();
    we = 0; rsv_en = 1; rsv_addr = 3'd0; tick();
    rsv_en = 0; ra1 = 3'd0; #1;
    n_tests++; if (rd1_o !== 8'h42 || busy1_o !== 1'b1) begin n_fail++; $display("FAIL plain_reg0: got rd %h busy %b want 42 1", rd1_o, busy1_o); end
    n_tests++; if (rd1_z !== 8'h00 || busy1_z !== 1'b0) begin n_fail++; $display("FAIL zero_reg0: got rd %h busy %b want 00 0", rd1_z, busy1_z); end
  endtask

  task automatic test_clear();
    int cnt;
    for (int a = 1; a < DEPTH; a++) begin we = 1; wa = AW'(a); wd = DW'(a); tick(); end
    we = 0; clr_req = 1; #1;
    n_tests++; if (clr_busy_z !== 1'b0) begin n_fail++; $display("FAIL clr_registered: got %b want 0", clr_busy_z); end
    tick();
    cnt = 0;
    for (int k = 0; k < 20 && clr_busy_z === 1'b1; k++) begin
      cnt++;
      we = 0; rsv_en = 0;
      if (cnt == 2) clr_req = 0;
      if (cnt == 3) begin
        ra1 = 3'd1; ra2 = 3'd7; #1;
        n_tests++; if (rd1_z !== 8'h00 || rd2_z !== 8'h07) begin n_fail++; $display("FAIL mid_sweep_rd: got %h %h want 00 07", rd1_z, rd2_z); end
      end
      if (cnt == 6) begin we = 1; wa = 3'd4; wd = 8'hEE; rsv_en = 1; rsv_addr = 3'd3; end
      tick();
    end
    idle_inputs();
    n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL clr_busy_len: got %0d want 8", cnt); end
    for (int a = 0; a < DEPTH; a++) begin
      ra1 = AW'(a); ra2 = AW'(a); #1;
      n_tests++;
      if (rd1_z !== 8'h00 || busy1_z !== 1'b0 || rd2_o !== 8'h00 || busy2_o !== 1'b0) begin
        n_fail++; $display("FAIL post_clear[%0d]: got %h %b %h %b want 00 0 00 0", a, rd1_z, busy1_z, rd2_o, busy2_o);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int a = 0; a < DEPTH; a++) begin we = 1; wa = AW'(a); wd = DW'($urandom_range(1, 255)); tick(); end
    we = 0; clr_req = 1; tick();
    clr_req = 0; tick(); tick();
    n_tests++; if (clr_busy_z !== 1'b1) begin n_fail++; $display("FAIL sweep_active: got %b want 1", clr_busy_z); end
    rst = 1; tick();
    rst = 0; #1;
    n_tests++; if (clr_busy_z !== 1'b0 || clr_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got %b/%b want 0/0", clr_busy_z, clr_busy_o); end
    for (int a = 0; a < DEPTH; a++) begin
      ra1 = AW'(a); #1;
      n_tests++; if (rd1_z !== 8'h00 || rd1_o !== 8'h00) begin n_fail++; $display("FAIL rst_zero[%0d]: got %h %h want 00 00", a, rd1_z, rd1_o); end
    end
    we = 1; wa = 3'd0; wd = 8'h33; tick();
    wa = 3'd1; wd = 8'h5A; tick();
    wa = 3'd7; wd = 8'h77; tick();
    we = 0; clr_req = 1; tick();
    clr_req = 0; tick(); tick();
    ra1 = 3'd1; ra2 = 3'd7; #1;
    n_tests++; if (rd1_z !== 8'h00 || rd2_z !== 8'h77) begin n_fail++; $display("FAIL restart_idx0: got %h %h want 00 77", rd1_z, rd2_z); end
    ra1 = 3'd0; #1;
    n_tests++; if (rd1_o !== 8'h00) begin n_fail++; $display("FAIL restart_reg0: got %h want 00", rd1_o); end
    for (int k = 0; k < 20 && clr_busy_z === 1'b1; k++) tick();
    n_tests++; if (clr_busy_z !== 1'b0) begin n_fail++; $display("FAIL sweep_end: got %b want 0", clr_busy_z); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    we = 1; wa = 3'd6; wd = 8'h21; tick();
    wd = 8'h9E; ra1 = 3'd6; #1;
`ifdef REGFILE_BYPASS_EN
    want = 8'h9E;
`else
    want = 8'h21;
`endif
    n_tests++; if (rd1_z !== want) begin n_fail++; $display("FAIL same_cycle_rd: got %h want %h", rd1_z, want); end
    tick();
    we = 0; #1;
    n_tests++; if (rd1_z !== 8'h9E) begin n_fail++; $display("FAIL next_cycle_rd: got %h want 9E", rd1_z); end
  endtask

  task automatic test_random();
    logic [2*DW+2:0] got_v, exp_v;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      we       = $urandom_range(0, 1) == 1;
      wa       = AW'($urandom);
      wd       = DW'($urandom);
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = AW'($urandom);
      clr_req  = ($urandom_range(0, 39) == 0);
      ra1      = AW'($urandom);
      ra2      = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      #1;
      got_v = {rd1_z, rd2_z, busy1_z, busy2_z, clr_busy_z};
      exp_v = {exp_rd(1, ra1), exp_rd(1, ra2), exp_busy(1, ra1), exp_busy(1, ra2), logic'(sw_on)};
      n_tests++; if (got_v !== exp_v) begin n_fail++; $display("FAIL rand_zero c%0d: got %h want %h", c, got_v, exp_v); end
      got_v = {rd1_o, rd2_o, busy1_o, busy2_o, clr_busy_o};
      exp_v = {exp_rd(0, ra1), exp_rd(0, ra2), exp_busy(0, ra1), exp_busy(0, ra2), logic'(sw_on)};
      n_tests++; if (got_v !== exp_v) begin n_fail++; $display("FAIL rand_plain c%0d: got %h want %h", c, got_v, exp_v); end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 0; ra1 = '0; ra2 = '0;
    for (int i = 0; i < DEPTH; i++) begin mz[i] = '0; mo[i] = '0; end
    pz = '0; po = '0; sw_on = 0; sw_pos = 0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_scoreboard();
    test_clear();
    test_reset_mid_sweep();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
